updown_reload_counter: RTL
==========================

# updown_reload_counter

Parametrised programmable counter: successor to the fixed 3-bit load/count-down counter. Adds configurable width, up or down direction, one-shot or auto-reload mode, a one-cycle terminal-count pulse and an optional tick prescaler. Sits beside the datapath as a general-purpose event/delay timer; `done` is backward compatible with the old 3-bit block when configured down/one-shot with `WIDTH=3`.

## Interface
- `WIDTH`, 8: counter and `count_to` width; ≥2.
- `PRESCALE`, 4: ticks per count step; ≥1. Used only when `COUNTER_PRESCALE_EN` is defined.
- `clk`  in  1  single clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `count_to`  in  WIDTH  terminal/reload value, sampled on `load`.
- `load`  in  1  load request; highest priority.
- `count_en`  in  1  count enable, level.
- `up_down`  in  1  direction, sampled on `load`; 0 = down (count_to→0), 1 = up (0→count_to).
- `auto_reload`  in  1  mode, sampled on `load`; 0 = one-shot, 1 = periodic.
- `count`  out  WIDTH  current value.
- `done`  out  1  one-shot complete, level.
- `tc_pulse`  out  1  terminal count reached, one cycle.
- `busy`  out  1  state RUN.

## Operation
- Registers: `count`, `reload` (WIDTH), `dir`, `mode`, state ∈ {IDLE, RUN, HOLD}.
- Reset: `count`=0, `done`=0, `tc_pulse`=0, `busy`=0, state IDLE, prescaler=0, `reload`=0.
- `load`=1 (any state): `reload`←`count_to`, `dir`←`up_down`, `mode`←`auto_reload`, `done`←0, prescaler←0.
  - `count`←`count_to` if down, 0 if up; state→RUN.
  - If `count_to`=0: state→HOLD, `count`←0, `done`←1, `tc_pulse`←1. The `done`←1 applies even with `auto_reload`=1 (degenerate period).
- RUN, on tick: down `count`−1, up `count`+1. When the next value equals the terminal (0 down, `reload` up), `tc_pulse`←1 with that value.
  - one-shot: state→HOLD, `done`←1.
  - auto-reload: stay RUN. The next tick reloads (`reload` down, 0 up) instead of stepping. Period = `reload`+1 ticks. `done` stays 0.
- No tick: `count` holds; `tc_pulse`=0.
- HOLD: `count` holds terminal value, `done`=1 until next `load`; `count_en` ignored.
- IDLE: `count_en` ignored; no counting before first `load`.
- Arithmetic is modulo 2^WIDTH but never wraps in practice: terminal detection precedes overflow/underflow.
- `up_down`/`auto_reload` changes outside `load` have no effect.

## Timing
- All outputs registered; no combinational input→output path.
- `load` at edge k: `count`, `busy` valid after edge k.
- Down, `count_en` held high, no prescale: `count`=N−i after edge k+i. `tc_pulse` high for the single cycle after edge k+N. `done` high from edge k+N.
- Up: identical, `count`=i.
- `load` and tick in same cycle: `load` wins, tick discarded.
- `reset_n` low mid-operation: all outputs at reset values immediately (asynchronous), independent of `clk`. Release is synchronised externally.

## Configuration
- `COUNTER_PRESCALE_EN` defined:
  - tick = `count_en` & (prescaler == `PRESCALE`−1) in RUN.
  - The prescaler counts while `count_en` is high in RUN, wraps at `PRESCALE`−1, clears on `load` and reset, and holds when `count_en` is low.
  - `PRESCALE`=1 behaves as the undefined case.
- Undefined: tick = `count_en` in RUN; no prescaler logic, `PRESCALE` ignored.

## Test plan
- `WIDTH`=3, down, one-shot, `count_to`=7, `load` 1 cycle, then `count_en`=1 → `count` 7,6,…,0 on successive edges. `tc_pulse` high exactly one cycle at 0. `done`=1 and `count`=0 held for 5 further cycles; `busy`=0.
- Up, auto-reload, `count_to`=3 → `count` 0,1,2,3,0,1,2,3. `tc_pulse` every 4th cycle coinciding with 3; `done` stays 0.
- Down run, `load` with `count_to`=2 while `count`=5 → `count`=2 next edge, `tc_pulse` two edges later; drop `count_en` 3 cycles at `count`=1 → `count` holds 1.
- `load` with `count_to`=0 → after that edge `done`=1, `tc_pulse`=1 for one cycle, `count`=0, `busy`=0.
- Assert `reset_n`=0 between edges at `count`=4 → `count`=0, `done`=0, `busy`=0 before next edge; no counting after release until `load`.
- `COUNTER_PRESCALE_EN`, `PRESCALE`=4, down, `count_to`=2 → `count` changes every 4 cycles; `tc_pulse`/`done` 8 cycles after `load`.

Source files
------------

// File: rtl/updown_reload_counter.sv
// updown_reload_counter: programmable up/down counter with one-shot or auto-reload mode and a terminal-count pulse.
// Define COUNTER_PRESCALE_EN to advance the count only once every PRESCALE enabled cycles.
module updown_reload_counter #(
    parameter int WIDTH    = 8,
    parameter int PRESCALE = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] count_to,
    input  logic             load,
    input  logic             count_en,
    input  logic             up_down,
    input  logic             auto_reload,
    output logic [WIDTH-1:0] count,
    output logic             done,
    output logic             tc_pulse,
    output logic             busy
);
    typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;
    state_t           r_state;
    logic [WIDTH-1:0] r_count, r_reload;
    logic             r_dir, r_mode, r_done, r_tc;
    logic             w_tick;
    logic [WIDTH-1:0] w_term, w_start, w_next;
`ifdef COUNTER_PRESCALE_EN
    localparam int PW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
    logic [PW-1:0] r_pre;
    logic          w_pre_wrap;
    assign w_pre_wrap = r_pre == PW'(PRESCALE - 1);
    assign w_tick     = r_state == RUN && count_en && w_pre_wrap;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_pre <= '0;
        else if (load)
            r_pre <= '0;
        else if (r_state == RUN && count_en)
            r_pre <= w_pre_wrap ? '0 : r_pre + PW'(1);
    end
`else
    assign w_tick = r_state == RUN && count_en && (PRESCALE > 0);
`endif
    assign w_term  = r_dir ? r_reload : '0;
    assign w_start = r_dir ? '0 : r_reload;
    // a step from the terminal value only happens in auto-reload, where it restarts the period
    assign w_next  = r_count == w_term ? w_start : (r_dir ? r_count + WIDTH'(1) : r_count - WIDTH'(1));
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= IDLE;
            r_count  <= '0;
            r_reload <= '0;
            r_dir    <= 1'b0;
            r_mode   <= 1'b0;
            r_done   <= 1'b0;
            r_tc     <= 1'b0;
        end else begin
            r_tc <= 1'b0;
            if (load) begin
                r_reload <= count_to;
                r_dir    <= up_down;
                r_mode   <= auto_reload;
                if (count_to == '0) begin
                    r_state <= HOLD;
                    r_count <= '0;
                    r_done  <= 1'b1;
                    r_tc    <= 1'b1;
                end else begin
                    r_state <= RUN;
                    r_count <= up_down ? '0 : count_to;
                    r_done  <= 1'b0;
                end
            end else if (w_tick) begin
                r_count <= w_next;
                if (w_next == w_term) begin
                    r_tc <= 1'b1;
                    if (!r_mode) begin
                        r_state <= HOLD;
                        r_done  <= 1'b1;
                    end
                end
            end
        end
    end
    assign count    = r_count;
    assign done     = r_done;
    assign tc_pulse = r_tc;
    assign busy     = r_state == RUN;
endmodule
